video_timing_gen: RTL

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, syncs, data enable and frame strobes, all registered against the same (x,y).
// Optional runtime timing handshake under VTG_RUNTIME_CFG_EN; the default build uses parameter timing only.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_h_active,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_bp,
  input  logic [CW-1:0] cfg_v_active,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_bp,
  output logic          cfg_ready,
  output logic          hsync,
  output logic          vsync,
  output logic          vde,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          sof,
  output logic          eol,
  output logic          eof,
  output logic          running,
  output logic [15:0]   frame_cnt
);

  localparam int TW = CW + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] h, v, h_nxt, v_nxt;
  logic          run_nxt;

  // Timing set that governs the cycle about to be registered.
  logic [CW-1:0] nxt_ha, nxt_hfp, nxt_hs, nxt_hbp;
  logic [CW-1:0] nxt_va, nxt_vfp, nxt_vs, nxt_vbp;

`ifdef VTG_RUNTIME_CFG_EN
  logic [CW-1:0] ha_q, hfp_q, hs_q, hbp_q;
  logic [CW-1:0] va_q, vfp_q, vs_q, vbp_q;
  logic          cfg_take;

  assign cfg_take  = cfg_valid && ((state == S_IDLE) || eof);
  assign cfg_ready = cfg_take && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ha_q  <= CW'(H_ACTIVE);
      hfp_q <= CW'(H_FP);
      hs_q  <= CW'(H_SYNC);
      hbp_q <= CW'(H_BP);
      va_q  <= CW'(V_ACTIVE);
      vfp_q <= CW'(V_FP);
      vs_q  <= CW'(V_SYNC);
      vbp_q <= CW'(V_BP);
    end else if (cfg_take) begin
      ha_q  <= cfg_h_active;
      hfp_q <= cfg_h_fp;
      hs_q  <= cfg_h_sync;
      hbp_q <= cfg_h_bp;
      va_q  <= cfg_v_active;
      vfp_q <= cfg_v_fp;
      vs_q  <= cfg_v_sync;
      vbp_q <= cfg_v_bp;
    end
  end

  // Acceptance only happens in IDLE or at eof, so the next cycle is always h=0,v=0 of the new set.
  assign nxt_ha  = cfg_take ? cfg_h_active : ha_q;
  assign nxt_hfp = cfg_take ? cfg_h_fp     : hfp_q;
  assign nxt_hs  = cfg_take ? cfg_h_sync   : hs_q;
  assign nxt_hbp = cfg_take ? cfg_h_bp     : hbp_q;
  assign nxt_va  = cfg_take ? cfg_v_active : va_q;
  assign nxt_vfp = cfg_take ? cfg_v_fp     : vfp_q;
  assign nxt_vs  = cfg_take ? cfg_v_sync   : vs_q;
  assign nxt_vbp = cfg_take ? cfg_v_bp     : vbp_q;
`else
  logic cfg_unused;
  assign cfg_unused = ^{cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
                        cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp};
  assign cfg_ready  = 1'b0;

  assign nxt_ha  = CW'(H_ACTIVE);
  assign nxt_hfp = CW'(H_FP);
  assign nxt_hs  = CW'(H_SYNC);
  assign nxt_hbp = CW'(H_BP);
  assign nxt_va  = CW'(V_ACTIVE);
  assign nxt_vfp = CW'(V_FP);
  assign nxt_vs  = CW'(V_SYNC);
  assign nxt_vbp = CW'(V_BP);
`endif

  // Window edges and last positions, widened so the sums cannot wrap.
  logic [TW-1:0] hs_start, hs_stop, h_last;
  logic [TW-1:0] vs_start, vs_stop, v_last;
  logic [TW-1:0] hn, vn;

  assign hs_start = TW'(nxt_ha) + TW'(nxt_hfp);
  assign hs_stop  = hs_start + TW'(nxt_hs);
  assign h_last   = hs_stop + TW'(nxt_hbp) - TW'(1);
  assign vs_start = TW'(nxt_va) + TW'(nxt_vfp);
  assign vs_stop  = vs_start + TW'(nxt_vs);
  assign v_last   = vs_stop + TW'(nxt_vbp) - TW'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_RUN;
      S_RUN:   if (!en) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (en)       state_nxt = S_RUN;
        else if (eof) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign run_nxt = (state_nxt != S_IDLE);

  // The registered eol/eof flags already describe the current position, so they drive the wrap.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (run_nxt && (state != S_IDLE)) begin
      if (eol) begin
        h_nxt = '0;
        v_nxt = eof ? '0 : v + CW'(1);
      end else begin
        h_nxt = h + CW'(1);
        v_nxt = v;
      end
    end
  end

  assign hn = TW'(h_nxt);
  assign vn = TW'(v_nxt);

  logic hs_on, vs_on, vde_nxt, sof_nxt, eol_nxt, eof_nxt;

  always_comb begin
    hs_on   = run_nxt && (hn >= hs_start) && (hn < hs_stop);
    vs_on   = run_nxt && (vn >= vs_start) && (vn < vs_stop);
    vde_nxt = run_nxt && (hn < TW'(nxt_ha)) && (vn < TW'(nxt_va));
    sof_nxt = run_nxt && (hn == '0) && (vn == '0);
    eol_nxt = run_nxt && (hn == h_last);
    eof_nxt = eol_nxt && (vn == v_last);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      h         <= '0;
      v         <= '0;
      hsync     <= ~HS_POL;
      vsync     <= ~VS_POL;
      vde       <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      running   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state   <= state_nxt;
      h       <= h_nxt;
      v       <= v_nxt;
      hsync   <= hs_on ? HS_POL : ~HS_POL;
      vsync   <= vs_on ? VS_POL : ~VS_POL;
      vde     <= vde_nxt;
      sof     <= sof_nxt;
      eol     <= eol_nxt;
      eof     <= eof_nxt;
      running <= run_nxt;
      if (eof) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign x = h;
  assign y = v;

endmodule
